// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory side of the load/store interface.
// funct3 encodings, responder FSM states and the captured request bundle.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: write strobes, store data replication,
// load extraction/extension and size/alignment legality.
module dmem_lane_fmt
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        uns;
  logic [31:0] rsh;

  // Unsigned variants exist only for loads.
  assign uns  = !we && (funct3 == F3_BU || funct3 == F3_HU);
  assign is_b = funct3 == F3_B || (uns && funct3 == F3_BU);
  assign is_h = funct3 == F3_H || (uns && funct3 == F3_HU);
  assign is_w = funct3 == F3_W;
  assign rsh  = rword >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = 32'h0;
    rdata_ext = 32'h0;
    bad       = 1'b0;
    unique case (1'b1)
      is_b: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'h0, rsh[7:0]}
                        : {{24{rsh[7]}}, rsh[7:0]};
      end
      is_h: begin
        bad      = addr_lo[0];
        be       = 4'b0011 << addr_lo;
        wdata_sh = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'h0, rsh[15:0]}
                        : {{16{rsh[15]}}, rsh[15:0]};
      end
      is_w: begin
        bad       = |addr_lo;
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait
// states, byte/half/word access with registered response channel.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int ADDR_MSB = IDX_W + 1;

  dmem_state_t state;
  dmem_req_t   cur;
  logic [3:0]  cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             oor;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wdata_sh;
  logic [31:0]      rdata_ext;
  logic             bad;
  logic             err;
  logic             fire;
  logic             do_wr;

  assign idx   = cur.addr[ADDR_MSB:2];
  assign oor   = |cur.addr[31:ADDR_MSB+1];
  assign rword = mem[idx];
  assign err   = bad | oor;

  // First RESP cycle performs the access and raises rsp_valid.
  assign fire  = state == RESP && !rsp_valid;
  assign do_wr = fire && cur.we && !err && !rst;

  dmem_lane_fmt u_fmt (
    .addr_lo   (cur.addr[1:0]),
    .funct3    (cur.funct3),
    .we        (cur.we),
    .wdata     (cur.wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .bad       (bad)
  );

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            cur       <= '{req_we, req_addr,
                           req_wdata, req_funct3};
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RESP;
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || cur.we) ? 32'h0 : rdata_ext;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (1 and 3 wait states), directed
// accesses, backpressure and reset-during-wait.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic [1:0]  busy;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [2:0]  req_funct3 [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
  );

  function automatic int ws(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compare on every rising rsp_valid.
  logic [1:0] prev_v = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    bit   empty;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] && !prev_v[d]) begin
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got rdata %h err %b want none",
                   d, rsp_rdata[d], rsp_err[d]);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rdata dut%0d", d), rsp_rdata[d], e.rdata);
          chk($sformatf("err dut%0d", d), {31'h0, rsp_err[d]}, {31'h0, e.err});
          chk($sformatf("latency dut%0d", d), cyc, e.acc + 1 + ws(d));
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic issue(int d, logic we, logic [31:0] addr,
                       logic [31:0] wdata, logic [2:0] f3,
                       logic [31:0] er, logic ee, bit push);
    int   budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_funct3[d] = f3;
    while (!req_ready[d] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got req_ready 0 want 1", d);
      req_valid[d] = 1'b0;
      return;
    end
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc + 1;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    req_funct3[d] = 3'($urandom);
  endtask

  task automatic drain(int d);
    int budget;
    budget = 0;
    @(negedge clk);
    while (budget < 50 &&
           !(req_ready[d] && !rsp_valid[d] &&
             ((d == 0) ? q0.size() == 0 : q1.size() == 0))) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got busy %b want idle", d, busy[d]);
    end
  endtask

  task automatic chk_reset_outs(int d, string tag);
    chk($sformatf("%s req_ready", tag), {31'h0, req_ready[d]}, 32'h0);
    chk($sformatf("%s rsp_valid", tag), {31'h0, rsp_valid[d]}, 32'h0);
    chk($sformatf("%s rsp_rdata", tag), rsp_rdata[d], 32'h0);
    chk($sformatf("%s rsp_err", tag), {31'h0, rsp_err[d]}, 32'h0);
    chk($sformatf("%s busy", tag), {31'h0, busy[d]}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst       = 2'b11;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      req_funct3[d] = 3'd0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs(0, "rst0");
    chk_reset_outs(1, "rst1");
    @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    chk("post_rst req_ready0", {31'h0, req_ready[0]}, 32'h1);
    chk("post_rst req_ready1", {31'h0, req_ready[1]}, 32'h1);

    issue(0, 1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0, 1);
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 0, 1);
    issue(0, 0, 32'h13, 32'h0, F3_B, 32'hFFFFFFDE, 0, 1);
    issue(0, 0, 32'h13, 32'h0, F3_BU, 32'h000000DE, 0, 1);
    issue(0, 0, 32'h10, 32'h0, F3_H, 32'hFFFFBEEF, 0, 1);
    issue(0, 0, 32'h12, 32'h0, F3_HU, 32'h0000DEAD, 0, 1);
    issue(0, 1, 32'h11, 32'hFFFFFF55, F3_B, 32'h0, 0, 1);
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'hDEAD55EF, 0, 1);
    issue(0, 1, 32'h12, 32'hABCD1234, F3_H, 32'h0, 0, 1);
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'h123455EF, 0, 1);

    issue(0, 0, 32'h12, 32'h0, F3_W, 32'h0, 1, 1);
    issue(0, 1, 32'h11, 32'h00007777, F3_H, 32'h0, 1, 1);
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'h123455EF, 0, 1);
    issue(0, 0, 32'h400, 32'h0, F3_W, 32'h0, 1, 1);
    issue(0, 0, 32'h10, 32'h0, 3'd3, 32'h0, 1, 1);
    issue(0, 1, 32'h10, 32'h0, F3_BU, 32'h0, 1, 1);
    drain(0);

    // Backpressure: response held, a new request must be ignored.
    rsp_ready[0] = 1'b0;
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'h123455EF, 0, 1);
    budget = 0;
    while (!rsp_valid[0] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    for (int i = 0; i < 5; i++) begin
      req_valid[0]  = 1'b1;
      req_we[0]     = 1'b1;
      req_addr[0]   = 32'h10;
      req_wdata[0]  = 32'h0BADF00D;
      req_funct3[0] = F3_W;
      @(negedge clk);
      chk("bp rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
      chk("bp rsp_rdata", rsp_rdata[0], 32'h123455EF);
      chk("bp rsp_err", {31'h0, rsp_err[0]}, 32'h0);
      chk("bp req_ready", {31'h0, req_ready[0]}, 32'h0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hs req_ready", {31'h0, req_ready[0]}, 32'h1);
    chk("hs rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    chk("hs busy", {31'h0, busy[0]}, 32'h0);
    issue(0, 0, 32'h10, 32'h0, F3_W, 32'h123455EF, 0, 1);
    drain(0);

    // Reset while a store sits in WAIT on the 3-wait-state responder.
    issue(1, 1, 32'h20, 32'h11223344, F3_W, 32'h0, 0, 1);
    drain(1);
    issue(1, 1, 32'h20, 32'hAAAAAAAA, F3_W, 32'h0, 0, 0);
    @(negedge clk);
    chk("wait busy", {31'h0, busy[1]}, 32'h1);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs(1, "midrst");
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("midrst req_ready", {31'h0, req_ready[1]}, 32'h1);
    issue(1, 0, 32'h20, 32'h0, F3_W, 32'h11223344, 0, 1);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
